// File: rtl/ext_arbiter.sv
// ext_arbiter: shares one 32-bit immediate-extension datapath between
// decode (port 0) and the branch/jump target unit (port 1).
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   reqN_valid/ready         request handshake per requester (N = 0, 1)
//   reqN_op/imm/tag          extension op, 16-bit immediate, opaque tag
//   resp_valid/ready         registered response handshake
//   resp_id/tag/data         owning port, echoed tag, extended value
//   busy_cnt                 saturating count of stalled-request cycles
module ext_arbiter #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [15:0]      req0_imm,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [15:0]      req1_imm,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic [7:0]       busy_cnt
);

  localparam logic [OP_W-1:0] OP_SIGN  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_HIGH  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SHAMT = OP_W'(3);

  logic             last_gnt_q, last_gnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [7:0]       busy_cnt_q, busy_cnt_d;

  logic             slot_free;
  logic             sel;
  logic             gnt;
  logic             stall;
  logic [OP_W-1:0]  gnt_op;
  logic [15:0]      gnt_imm;
  logic [TAG_W-1:0] gnt_tag;
  logic [31:0]      ext_val;

  // Selected port depends only on valids and last_gnt, never on ready,
  // so ready can be offered before valid rises.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_gnt_q;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign slot_free  = !resp_valid_q || resp_ready;
  assign req0_ready = slot_free && !sel;
  assign req1_ready = slot_free && sel;

  assign gnt = (req0_valid && req0_ready) ||
               (req1_valid && req1_ready);

  assign stall = (req0_valid && !req0_ready) ||
                 (req1_valid && !req1_ready);

  always_comb begin
    gnt_op  = req0_op;
    gnt_imm = req0_imm;
    gnt_tag = req0_tag;
    if (sel) begin
      gnt_op  = req1_op;
      gnt_imm = req1_imm;
      gnt_tag = req1_tag;
    end
  end

  always_comb begin
    ext_val = {16'b0, gnt_imm};
    case (gnt_op)
      OP_SIGN:  ext_val = {{16{gnt_imm[15]}}, gnt_imm};
      OP_HIGH:  ext_val = {gnt_imm, 16'b0};
      OP_SHAMT: ext_val = {27'b0, gnt_imm[10:6]};
      default:  ext_val = {16'b0, gnt_imm};
    endcase
  end

  always_comb begin
    last_gnt_d   = last_gnt_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    if (gnt) begin
      last_gnt_d   = sel;
      resp_valid_d = 1'b1;
      resp_id_d    = sel;
      resp_tag_d   = gnt_tag;
      resp_data_d  = ext_val;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (stall && busy_cnt_q != 8'hFF) begin
      busy_cnt_d = busy_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      busy_cnt_q   <= '0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_tag   = resp_tag_q;
  assign resp_data  = resp_data_q;
  assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter: directed stimulus for ext_arbiter with a queue
// scoreboard popped by a monitor on each response handshake.
module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_imm = '0, req1_imm = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic        resp_valid, resp_id;
  logic        resp_ready = 1'b0;
  logic [3:0]  resp_tag;
  logic [31:0] resp_data;
  logic [7:0]  busy_cnt;

  logic [31:0] exp0 = '0, exp1 = '0;
  logic [36:0] sb_q[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ext_arbiter #(.TAG_W(4), .OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_imm(req0_imm), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_imm(req1_imm), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_tag(resp_tag), .resp_data(resp_data),
    .busy_cnt(busy_cnt)
  );

  task automatic check(input string name,
                       input logic [36:0] act,
                       input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [1:0] op, input logic [15:0] imm,
                       input logic [3:0] tag, input logic [31:0] e);
    req0_op = op; req0_imm = imm; req0_tag = tag; exp0 = e;
    req0_valid = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("send0_ready", 37'(req0_ready), 37'd1);
    tick();
    req0_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] b0;
    logic [7:0] b3;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sb_unexpected: got %h expected none",
                       {resp_id, resp_tag, resp_data});
            end else begin
              check("sb_resp", {resp_id, resp_tag, resp_data},
                    sb_q.pop_front());
            end
          end
          if (req0_valid && req0_ready)
            sb_q.push_back({1'b0, req0_tag, exp0});
          if (req1_valid && req1_ready)
            sb_q.push_back({1'b1, req1_tag, exp1});
        end
      end
    join_none

    // Reset values
    #2;
    check("rst_resp_valid", 37'(resp_valid), 37'd0);
    check("rst_fields", {resp_id, resp_tag, resp_data}, 37'd0);
    check("rst_busy", 37'(busy_cnt), 37'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single sign-extend request
    req0_op = 2'd1; req0_imm = 16'h8001; req0_tag = 4'd3;
    exp0 = 32'hFFFF8001;
    req0_valid = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("t1_ready0", 37'(req0_ready), 37'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_resp_valid", 37'(resp_valid), 37'd1);
    check("t1_resp", {resp_id, resp_tag, resp_data},
          {1'b0, 4'd3, 32'hFFFF8001});
    tick();

    // 2: tie after reset alternates 0,1,0,1
    rst_n = 1'b0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    req0_op = 2'd0; req0_imm = 16'h1234; req0_tag = 4'd1;
    exp0 = 32'h00001234;
    req1_op = 2'd2; req1_imm = 16'hABCD; req1_tag = 4'd2;
    exp1 = 32'hABCD0000;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_rdy", {35'd0, req0_ready, req1_ready},
            (i % 2 == 0) ? 37'b10 : 37'b01);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();

    // 3: stall while response is held
    resp_ready = 1'b0;
    req0_op = 2'd0; req0_imm = 16'h0042; req0_tag = 4'd5;
    exp0 = 32'h00000042;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_op = 2'd2; req1_imm = 16'h0007; req1_tag = 4'd9;
    exp1 = 32'h00070000;
    req1_valid = 1'b1;
    b0 = busy_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_ready1_low", 37'(req1_ready), 37'd0);
      check("t3_hold", {resp_valid, resp_tag, resp_data},
            {1'b1, 4'd5, 32'h00000042});
      tick();
    end
    b3 = b0 + 8'd3;
    check("t3_busy", 37'(busy_cnt), 37'(b3));
    resp_ready = 1'b1;
    @(negedge clk);
    check("t3_ready1_high", 37'(req1_ready), 37'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();

    // 4: extension ops
    send0(2'd3, 16'b00000_10110_000000, 4'd6, 32'h00000016);
    send0(2'd0, 16'hFFFF, 4'd7, 32'h0000FFFF);
    send0(2'd1, 16'h7FFF, 4'd8, 32'h00007FFF);
    send0(2'd2, 16'h0001, 4'd10, 32'h00010000);
    tick();
    check("t4_drained", 37'(sb_q.size()), 37'd0);

    // 5: saturation
    resp_ready = 1'b0;
    req0_op = 2'd1; req0_imm = 16'h0003; req0_tag = 4'd1;
    exp0 = 32'h00000003;
    req0_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("t5_busy_sat", 37'(busy_cnt), 37'd255);
    check("t5_held", {resp_valid, resp_data}, {1'b1, 32'h00000003});

    // 6: asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    sb_q.delete();
    #1;
    check("t6_valid_drop", 37'(resp_valid), 37'd0);
    check("t6_rst_vals", {busy_cnt, resp_id, resp_data}, 37'd0);
    tick();
    rst_n = 1'b1;
    req0_op = 2'd0; req0_imm = 16'h0011; req0_tag = 4'd2;
    exp0 = 32'h00000011;
    req1_op = 2'd0; req1_imm = 16'h0022; req1_tag = 4'd4;
    exp1 = 32'h00000022;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("t6_tie", {35'd0, req0_ready, req1_ready}, 37'b10);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t6_only1", 37'(req1_ready), 37'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    check("final_drained", 37'(sb_q.size()), 37'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
